// File: rtl/counter_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// counter_cmd_arbiter
//
// Shares a single up/down loadable counter between NUM_REQ requesters.
// Each requester posts one command (load, count up N, count down N, read).
// The arbiter grants requesters one at a time in round-robin order, drives
// the counter control pins for as many cycles as the command needs, samples
// the counter once its output has settled, and returns that value with a
// one-cycle done pulse to the granted requester.
//
// Ports
//   clk           in   clock, all logic on posedge
//   reset         in   asynchronous active-low reset
//   req           in   [NUM_REQ]      per-requester request level
//   req_op        in   [2*NUM_REQ]    op per requester: 00 load, 01 up,
//                                     10 down, 11 read
//   req_data      in   [WIDTH*NUM_REQ] load value; low STEP_W bits are the
//                                     step count for up/down
//   gnt           out  [NUM_REQ]      one-hot grant, held for the whole command
//   done          out  [NUM_REQ]      one-cycle completion pulse
//   rsp_data      out  [WIDTH]        counter value, valid while done is high
//   busy          out                 high whenever the sequencer is not idle
//   cnt_enable    out                 counter count enable
//   cnt_updown    out                 counter direction, 1 = up
//   cnt_load      out                 counter synchronous load
//   cnt_data_in   out  [WIDTH]        counter load value
//   cnt_data_out  in   [WIDTH]        counter registered output
// ---------------------------------------------------------------------------
module counter_cmd_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int STEP_W  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [2*NUM_REQ-1:0]       req_op,
   input  logic [WIDTH*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic [WIDTH-1:0]           rsp_data,
   output logic                       busy,
   output logic                       cnt_enable,
   output logic                       cnt_updown,
   output logic                       cnt_load,
   output logic [WIDTH-1:0]           cnt_data_in,
   input  logic [WIDTH-1:0]           cnt_data_out
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_WAIT = 2'b10,
      S_RESP = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_UP   = 2'b01,
      OP_DOWN = 2'b10,
      OP_READ = 2'b11
   } op_t;

   // Registered state
   state_t              state_q;
   op_t                 op_q;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [STEP_W-1:0]   steps_q;

   // Next-state values
   state_t              state_d;
   op_t                 op_d;
   logic [IDX_W-1:0]    idx_d;
   logic [IDX_W-1:0]    ptr_d;
   logic [STEP_W-1:0]   steps_d;
   logic [NUM_REQ-1:0]  gnt_d;
   logic [NUM_REQ-1:0]  done_d;
   logic [WIDTH-1:0]    rsp_d;
   logic                enable_d;
   logic                updown_d;
   logic                load_d;
   logic [WIDTH-1:0]    data_in_d;

   // Arbitration results
   logic                found;
   logic [IDX_W-1:0]    win_idx;
   op_t                 win_op;
   logic [WIDTH-1:0]    win_data;
   logic [STEP_W-1:0]   win_steps;

   // ------------------------------------------------------------------------
   // Round-robin winner: the first high req at or above ptr, otherwise the
   // first high req below ptr (the search wraps modulo NUM_REQ).
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      found   = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[k] && (IDX_W'(k) >= ptr_q)) begin
            found   = 1'b1;
            win_idx = IDX_W'(k);
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[k]) begin
            found   = 1'b1;
            win_idx = IDX_W'(k);
         end
      end
   end

   // Select the winner's op and data slices.
   always_comb begin
      win_op   = OP_LOAD;
      win_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_idx == IDX_W'(k)) begin
            win_op   = op_t'(req_op[2*k +: 2]);
            win_data = req_data[WIDTH*k +: WIDTH];
         end
      end
   end

   assign win_steps = win_data[STEP_W-1:0];

   // ------------------------------------------------------------------------
   // Next-state and next-output logic. The counter controls, grant and done
   // are registered, so they are computed here for the state being entered.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      steps_d   = steps_q;
      rsp_d     = rsp_data;
      enable_d  = 1'b0;
      updown_d  = 1'b0;
      load_d    = 1'b0;
      data_in_d = '0;
      gnt_d     = '0;
      done_d    = '0;

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               op_d  = win_op;
               idx_d = win_idx;
               unique case (win_op)
                  OP_LOAD: begin
                     // The load value is held in cnt_data_in for the single
                     // EXEC cycle, so no separate data register is needed.
                     state_d   = S_EXEC;
                     load_d    = 1'b1;
                     data_in_d = win_data;
                     steps_d   = '0;
                  end
                  OP_UP, OP_DOWN: begin
                     steps_d = win_steps;
                     if (win_steps == '0) begin
                        state_d = S_WAIT;
                     end else begin
                        state_d  = S_EXEC;
                        enable_d = 1'b1;
                        updown_d = (win_op == OP_UP);
                     end
                  end
                  default: begin
                     state_d = S_WAIT;
                     steps_d = '0;
                  end
               endcase
            end
         end

         S_EXEC: begin
            // steps_q counts the enable cycles still to run, including the
            // current one; the last one hands over to WAIT.
            if (op_q == OP_LOAD || steps_q <= STEP_W'(1)) begin
               state_d = S_WAIT;
               steps_d = '0;
            end else begin
               steps_d  = steps_q - 1'b1;
               enable_d = 1'b1;
               updown_d = (op_q == OP_UP);
            end
         end

         S_WAIT: begin
            // The counter has absorbed the last EXEC edge; sample it now.
            state_d = S_RESP;
            rsp_d   = cnt_data_out;
            for (int k = 0; k < NUM_REQ; k++) begin
               done_d[k] = (idx_q == IDX_W'(k));
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
            if (idx_q == IDX_W'(NUM_REQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = idx_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Grant follows the latched index for every cycle outside IDLE.
      for (int k = 0; k < NUM_REQ; k++) begin
         gnt_d[k] = (state_d != S_IDLE) && (idx_d == IDX_W'(k));
      end
   end

   // ------------------------------------------------------------------------
   // State and output registers. Reset aborts any command in flight: all
   // controls drop at once and no done is issued.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LOAD;
         idx_q       <= '0;
         ptr_q       <= '0;
         steps_q     <= '0;
         gnt         <= '0;
         done        <= '0;
         rsp_data    <= '0;
         cnt_enable  <= 1'b0;
         cnt_updown  <= 1'b0;
         cnt_load    <= 1'b0;
         cnt_data_in <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         ptr_q       <= ptr_d;
         steps_q     <= steps_d;
         gnt         <= gnt_d;
         done        <= done_d;
         rsp_data    <= rsp_d;
         cnt_enable  <= enable_d;
         cnt_updown  <= updown_d;
         cnt_load    <= load_d;
         cnt_data_in <= data_in_d;
      end
   end

   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_cmd_arbiter
//
// Drives batches of commands into counter_cmd_arbiter, with a behavioural
// counter attached to the cnt_* pins. Expected responses come from an
// arithmetic model (round-robin order over the pending set, counter value
// modulo 256) and are queued; a monitor compares them whenever done pulses.
// ---------------------------------------------------------------------------
module tb_counter_cmd_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int STEP_W  = 4;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic [NUM_REQ-1:0]       req = '0;
   logic [2*NUM_REQ-1:0]     req_op = '0;
   logic [WIDTH*NUM_REQ-1:0] req_data = '0;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       done;
   logic [WIDTH-1:0]         rsp_data;
   logic                     busy;
   logic                     cnt_enable;
   logic                     cnt_updown;
   logic                     cnt_load;
   logic [WIDTH-1:0]         cnt_data_in;
   logic [WIDTH-1:0]         cnt_q = '0;

   typedef struct {
      int         idx;
      int         op;
      logic [7:0] data;
      logic [7:0] value;
      int         busy_cycles;
      int         enables;
      int         ups;
      int         loads;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         errors = 0;
   int         checks = 0;
   logic [7:0] model_val = 8'h00;
   int         model_ptr = 0;

   int         mon_busy = 0;
   int         mon_en = 0;
   int         mon_up = 0;
   int         mon_ld = 0;

   always #5 clk = ~clk;

   counter_cmd_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .STEP_W  (STEP_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_op       (req_op),
      .req_data     (req_data),
      .gnt          (gnt),
      .done         (done),
      .rsp_data     (rsp_data),
      .busy         (busy),
      .cnt_enable   (cnt_enable),
      .cnt_updown   (cnt_updown),
      .cnt_load     (cnt_load),
      .cnt_data_in  (cnt_data_in),
      .cnt_data_out (cnt_q)
   );

   // The shared counter: registered, load has priority, wraps modulo 256.
   always @(posedge clk) begin
      if (cnt_load)
         cnt_q <= cnt_data_in;
      else if (cnt_enable)
         cnt_q <= cnt_updown ? cnt_q + 8'd1 : cnt_q - 8'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: per-cycle protocol checks and scoreboard comparison on done.
   always @(negedge clk) begin
      if (!reset) begin
         mon_busy = 0; mon_en = 0; mon_up = 0; mon_ld = 0;
      end else begin
         check("load_enable_exclusive", 32'(cnt_load & cnt_enable), 32'd0);
         if (!busy) begin
            check("idle_controls", 32'({cnt_enable, cnt_updown, cnt_load, cnt_data_in}), 32'd0);
            check("idle_gnt_done", 32'({gnt, done}), 32'd0);
            mon_busy = 0; mon_en = 0; mon_up = 0; mon_ld = 0;
         end else begin
            mon_busy++;
            if (cnt_enable) mon_en++;
            if (cnt_enable && cnt_updown) mon_up++;
            if (cnt_load) mon_ld++;
            if (!cnt_enable) check("updown_without_enable", 32'(cnt_updown), 32'd0);
            if (!cnt_load) check("data_in_outside_load", 32'(cnt_data_in), 32'd0);
            if (exp_q.size() > 0) begin
               check("gnt_onehot", 32'(gnt), 32'(1) << exp_q[0].idx);
               if (cnt_load) check("load_value", 32'(cnt_data_in), 32'(exp_q[0].data));
            end
            if (done != '0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'(done), 32'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("done_index", 32'(done), 32'(1) << mon_e.idx);
                  check("rsp_data", 32'(rsp_data), 32'(mon_e.value));
                  check("latency_cycles", 32'(mon_busy), 32'(mon_e.busy_cycles));
                  check("enable_cycles", 32'(mon_en), 32'(mon_e.enables));
                  check("up_cycles", 32'(mon_up), 32'(mon_e.ups));
                  check("load_cycles", 32'(mon_ld), 32'(mon_e.loads));
               end
            end
         end
      end
   end

   // Issue a set of simultaneous commands from an idle DUT; the model queues
   // the responses in round-robin order, then each requester drops its req
   // right after its done pulse.
   task automatic run_batch(input logic [3:0] mask, input logic [7:0] ops, input logic [31:0] datas);
      exp_t       e;
      logic [3:0] d;
      int         n;
      int         p;
      int         i;
      p = model_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         i = (p + k) % NUM_REQ;
         if (mask[i]) begin
            e.idx     = i;
            e.op      = int'(ops[2*i +: 2]);
            e.data    = datas[8*i +: 8];
            n         = int'(e.data[3:0]);
            e.enables = 0;
            e.ups     = 0;
            e.loads   = 0;
            case (e.op)
               0: begin model_val = e.data; e.busy_cycles = 3; e.loads = 1; end
               1: begin
                  model_val = model_val + 8'(n);
                  e.enables = n; e.ups = n;
                  e.busy_cycles = (n == 0) ? 2 : n + 2;
               end
               2: begin
                  model_val = model_val - 8'(n);
                  e.enables = n;
                  e.busy_cycles = (n == 0) ? 2 : n + 2;
               end
               default: e.busy_cycles = 2;
            endcase
            e.value = model_val;
            exp_q.push_back(e);
            model_ptr = (i + 1) % NUM_REQ;
         end
      end
      req_op   = ops;
      req_data = datas;
      req      = mask;
      for (int c = 0; c < 400 && req != '0; c++) begin
         @(negedge clk);
         d = done;
         @(posedge clk);
         #1;
         req = req & ~d;
      end
      check("batch_complete", 32'(req), 32'd0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      if (req != '0 || exp_q.size() != 0) begin
         req = '0;
         exp_q.delete();
      end
   endtask

   logic [7:0] abort_start;
   int         n_en;

   initial begin
      // Reset held with all requesters asking for a read.
      req_op = 8'hFF;
      req    = 4'hF;
      #1 reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("reset_outputs",
               32'({gnt, done, busy, cnt_enable, cnt_updown, cnt_load, cnt_data_in, rsp_data}),
               32'd0);
      end
      @(posedge clk);
      #1 reset = 1'b1;

      // Round robin: all four read, then requesters 0 and 2.
      run_batch(4'b1111, 8'hFF, 32'h0000_0000);
      run_batch(4'b0101, 8'hFF, 32'h0000_0000);

      // Load 0x5A on requester 0.
      run_batch(4'b0001, 8'h00, 32'h0000_005A);
      // Load 0xFE on requester 2, then up 3 on requester 1 (wraps to 0x01).
      run_batch(4'b0100, 8'h00, 32'h00FE_0000);
      run_batch(4'b0010, 8'h04, 32'h0000_0300);
      // Zero-step downs; requester 0 has upper data bits set that are ignored.
      run_batch(4'b1001, 8'h82, 32'h0000_00F0);
      // Maximum step count.
      run_batch(4'b0100, 8'h10, 32'h000F_0000);

      // Randomized batches.
      for (int b = 0; b < 40; b++) begin
         run_batch(4'($urandom_range(1, 15)), 8'($urandom), $urandom);
      end

      // Leave the pointer at 2 so the post-reset restart is observable.
      run_batch(4'b0010, 8'h0C, 32'h0000_0000);

      // Reset in the middle of a 10-step up command.
      abort_start = cnt_q;
      req_op   = 8'h01;
      req_data = 32'h0000_000A;
      req      = 4'b0001;
      n_en     = 0;
      for (int c = 0; c < 50 && n_en < 4; c++) begin
         @(negedge clk);
         if (cnt_enable) n_en++;
      end
      check("abort_enables_seen", 32'(n_en), 32'd4);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort_controls_drop",
            32'({cnt_enable, cnt_load, cnt_updown, busy, gnt, done}), 32'd0);
      req = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      check("abort_counter_advance", 32'(cnt_q), 32'(8'(abort_start + 8'd4)));
      model_val = abort_start + 8'd4;
      model_ptr = 0;
      repeat (6) @(posedge clk);
      #1;

      // After reset, requester 0 has priority again: 0 before 3.
      run_batch(4'b1001, 8'hFF, 32'h0000_0000);

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
